// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request arbiter: FSM encoding and counter sizing.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_ITERATIONS = 16;
    localparam int unsigned DEF_CNT_W      = $clog2(DEF_ITERATIONS + 1);

    // Run counter must hold the value ITERATIONS itself.
    function automatic int unsigned cnt_width(input int unsigned iterations);
        return $clog2(iterations + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after start (wrapping), one-hot out.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(start) + i) % N;
            for (int unsigned k = 0; k < N; k++) begin
                if (!found && (idx == k) && req[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one iterative CORDIC core between N_REQ requesters with round-robin grant,
// returning each result only to the requester that issued the operation.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ITERATIONS = 16,
    parameter int unsigned XY_W       = 17,
    parameter int unsigned TH_W       = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*XY_W-1:0] req_x,
    input  logic [N_REQ*XY_W-1:0] req_y,
    input  logic [N_REQ*TH_W-1:0] req_theta,
    output logic                  cor_init,
    output logic [XY_W-1:0]       cor_x,
    output logic [XY_W-1:0]       cor_y,
    output logic [TH_W-1:0]       cor_theta,
    input  logic [XY_W-1:0]       cor_x_o,
    input  logic [XY_W-1:0]       cor_y_o,
    input  logic [TH_W-1:0]       cor_theta_o,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [XY_W-1:0]       rsp_x,
    output logic [XY_W-1:0]       rsp_y,
    output logic [TH_W-1:0]       rsp_theta,
    output logic                  busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = cnt_width(ITERATIONS);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 cor_init_q, cor_init_d;
    logic [XY_W-1:0]      cor_x_q, cor_x_d, cor_y_q, cor_y_d;
    logic [TH_W-1:0]      cor_th_q, cor_th_d;
    logic [XY_W-1:0]      rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
    logic [TH_W-1:0]      rsp_th_q, rsp_th_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                 busy_q, busy_d;

    logic [IDX_W-1:0]     start_c;
    logic [N_REQ-1:0]     grant_c;
    logic [IDX_W-1:0]     gnt_idx_c;
    logic [XY_W-1:0]      sel_x_c, sel_y_c;
    logic [TH_W-1:0]      sel_th_c;
    logic                 accept_c;
    logic                 rsp_done_c;

    // Search begins one past the last owner so every requester gets a turn.
    assign start_c = (last_q == IDX_W'(N_REQ - 1)) ? '0 : last_q + IDX_W'(1);

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (start_c),
        .grant (grant_c)
    );

    // Ready is a live view of the grant so a withdrawn request is never latched.
    assign req_ready  = ((state_q == ST_IDLE) && rst) ? grant_c : '0;
    assign accept_c   = |req_ready;
    assign rsp_done_c = |(rsp_valid_q & rsp_ready);

    always_comb begin
        gnt_idx_c = '0;
        sel_x_c   = '0;
        sel_y_c   = '0;
        sel_th_c  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_c[k]) begin
                gnt_idx_c = IDX_W'(k);
                sel_x_c   = req_x[k*XY_W +: XY_W];
                sel_y_c   = req_y[k*XY_W +: XY_W];
                sel_th_c  = req_theta[k*TH_W +: TH_W];
            end
        end
    end

    // The run counter spans the core iterations plus the cycle the final result settles in.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        cor_x_d     = cor_x_q;
        cor_y_d     = cor_y_q;
        cor_th_d    = cor_th_q;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_th_d    = rsp_th_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cor_x_d  = sel_x_c;
                    cor_y_d  = sel_y_c;
                    cor_th_d = sel_th_c;
                    last_d   = gnt_idx_c;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = CNT_W'(ITERATIONS);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    rsp_x_d     = cor_x_o;
                    rsp_y_d     = cor_y_o;
                    rsp_th_d    = cor_theta_o;
                    rsp_valid_d = N_REQ'(1) << last_q;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (rsp_done_c) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cor_init_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            cor_init_q  <= 1'b0;
            cor_x_q     <= '0;
            cor_y_q     <= '0;
            cor_th_q    <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_th_q    <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            cor_init_q  <= cor_init_d;
            cor_x_q     <= cor_x_d;
            cor_y_q     <= cor_y_d;
            cor_th_q    <= cor_th_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_th_q    <= rsp_th_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cor_init  = cor_init_q;
    assign cor_x     = cor_x_q;
    assign cor_y     = cor_y_q;
    assign cor_theta = cor_th_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_theta = rsp_th_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule
